// File: rtl/hall_emulator_if.sv
// Command and status bundle between a motion controller and hall_emulator.
interface hall_emulator_if #(
   parameter int PERIOD_W = 16
);
   logic                start;
   logic                stop;
   logic [7:0]          count;
   logic                dir;
   logic [PERIOD_W-1:0] period;
   logic [2:0]          h;
   logic [2:0]          sector;
   logic                step_stb;
   logic                busy;
   logic                done;

   modport master (
      output start, stop, count, dir, period,
      input  h, sector, step_stb, busy, done
   );

   modport slave (
      input  start, stop, count, dir, period,
      output h, sector, step_stb, busy, done
   );
endinterface

// File: rtl/hall_emulator.sv
// Emulates a 3-phase Hall sensor sequence stepping at PERIOD timebase ticks per sector.
// Optional macro HALL_PERIOD_LATCH_EN: PERIOD is sampled on START and at each step boundary.
module hall_emulator #(
   parameter int PRESC    = 49,
   parameter int PERIOD_W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   hall_emulator_if.slave bus
);
   localparam int                PC_W      = (PRESC > 0) ? $clog2(PRESC + 1) : 1;
   localparam logic [PC_W-1:0]   PRESC_MAX = PC_W'(PRESC);
   localparam logic [PERIOD_W:0] ONE       = (PERIOD_W + 1)'(1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state;
   logic [PC_W-1:0]     presc_cnt;
   logic [PERIOD_W-1:0] timer;
   logic [7:0]          remaining;
   logic [PERIOD_W-1:0] period_eff;
   logic                start_ok;
   logic                tick;
   logic                step_due;
   logic [2:0]          next_sector;

   function automatic logic [2:0] sector_to_h(input logic [2:0] s);
      case (s)
         3'd0:    sector_to_h = 3'b001;
         3'd1:    sector_to_h = 3'b011;
         3'd2:    sector_to_h = 3'b010;
         3'd3:    sector_to_h = 3'b110;
         3'd4:    sector_to_h = 3'b100;
         default: sector_to_h = 3'b101;
      endcase
   endfunction

   function automatic logic [2:0] advance(input logic [2:0] s, input logic fwd);
      if (fwd) advance = (s == 3'd5) ? 3'd0 : s + 3'd1;
      else     advance = (s == 3'd0) ? 3'd5 : s - 3'd1;
   endfunction

   // START together with STOP counts as STOP, so it never launches a move.
   assign start_ok    = bus.start && !bus.stop;
   assign tick        = (state == RUN) && (presc_cnt == PRESC_MAX);
   assign step_due    = tick && (period_eff != '0) &&
                        (({1'b0, timer} + ONE) >= {1'b0, period_eff});
   assign next_sector = advance(bus.sector, bus.dir);

`ifdef HALL_PERIOD_LATCH_EN
   logic [PERIOD_W-1:0] period_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_q <= '0;
      end else if ((state == IDLE && start_ok) || step_due) begin
         period_q <= bus.period;
      end
   end

   assign period_eff = period_q;
`else
   assign period_eff = bus.period;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         presc_cnt    <= '0;
         timer        <= '0;
         remaining    <= '0;
         bus.sector   <= 3'd0;
         bus.h        <= 3'b001;
         bus.step_stb <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
      end else begin
         bus.step_stb <= 1'b0;
         bus.done     <= 1'b0;
         case (state)
            IDLE: begin
               presc_cnt <= '0;
               timer     <= '0;
               if (start_ok) begin
                  state     <= RUN;
                  bus.busy  <= 1'b1;
                  remaining <= bus.count;
               end
            end
            RUN: begin
               if (bus.stop) begin
                  state     <= IDLE;
                  bus.busy  <= 1'b0;
                  presc_cnt <= '0;
                  timer     <= '0;
                  remaining <= '0;
               end else begin
                  presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
                  if (step_due) begin
                     timer        <= '0;
                     bus.sector   <= next_sector;
                     bus.h        <= sector_to_h(next_sector);
                     bus.step_stb <= 1'b1;
                     // remaining == 0 means continuous: it is never decremented.
                     if (remaining == 8'd1) begin
                        state     <= IDLE;
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        remaining <= '0;
                        presc_cnt <= '0;
                     end else if (remaining != 8'd0) begin
                        remaining <= remaining - 8'd1;
                     end
                  end else if (tick) begin
                     timer <= timer + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hall_emulator.sv
// Randomized self-checking bench for hall_emulator against a step-time arithmetic model.
`timescale 1ns/1ps
module tb_hall_emulator;
   localparam int PRESC    = 49;
   localparam int PERIOD_W = 16;
   localparam int TPS      = PRESC + 1;
   // Hall pattern of sector s sits at bits [3s+2:3s].
   localparam logic [17:0] H_TAB = {3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

   logic clk = 1'b0;
   logic rst_n;

   hall_emulator_if #(.PERIOD_W(PERIOD_W)) bus ();

   hall_emulator #(.PRESC(PRESC), .PERIOD_W(PERIOD_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   bit m_en;
   bit m_busy, m_stb, m_done;
   int m_sector, m_elapsed, m_left;

   logic [2:0] seen_h[$];
   int         stb_rel[$];
   int         done_cnt, done_wo_stb, rel;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic logic [8:0] outs();
      return {bus.h, bus.sector, bus.step_stb, bus.busy, bus.done};
   endfunction

   function automatic logic [8:0] exp_outs();
      return {H_TAB[m_sector*3 +: 3], 3'(m_sector), m_stb, m_busy, m_done};
   endfunction

   task automatic model_reset();
      m_busy = 0; m_stb = 0; m_done = 0;
      m_sector = 0; m_elapsed = 0; m_left = 0;
   endtask

   // Steps fall every PERIOD*(PRESC+1) cycles after the move starts.
   task automatic model_edge();
      m_stb  = 0;
      m_done = 0;
      if (!m_busy) begin
         if (bus.start && !bus.stop) begin
            m_busy = 1; m_elapsed = 0; m_left = int'(bus.count);
         end
      end else if (bus.stop) begin
         m_busy = 0;
      end else begin
         m_elapsed++;
         if (bus.period != 0 && m_elapsed % (int'(bus.period) * TPS) == 0) begin
            m_sector = bus.dir ? (m_sector + 1) % 6 : (m_sector + 5) % 6;
            m_stb = 1;
            if (m_left == 1) begin m_busy = 0; m_done = 1; end
            if (m_left > 0) m_left--;
         end
      end
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      rel++;
      if (m_en) check("outs", 32'(outs()), 32'(exp_outs()));
      if (bus.step_stb) begin
         seen_h.push_back(bus.h);
         stb_rel.push_back(rel);
      end
      if (bus.done) begin
         done_cnt++;
         if (!bus.step_stb) done_wo_stb++;
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1; cyc(); bus.start = 1'b0; rel = 0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
   endtask

   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      #1 check(tag, 32'(outs()), 32'(9'b001_000_000));
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check(tag, 32'(outs()), 32'(9'b001_000_000));
      rst_n = 1'b1;
   endtask

   initial begin
      int lim, gap1, gap2, step_at, exp_at;
      bus.start = 1'b0; bus.stop = 1'b0; bus.count = 8'd0;
      bus.dir = 1'b1; bus.period = 16'd2;
      rst_n = 1'b0;
      m_en = 1'b1;
      model_reset();
      done_cnt = 0; done_wo_stb = 0; rel = 0;

      @(negedge clk);
      check("rst_state", 32'(outs()), 32'(9'b001_000_000));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) cyc();
      bus.start = 1'b1; bus.stop = 1'b1; cyc(); bus.start = 1'b0; bus.stop = 1'b0;
      repeat (3) cyc();

      // Continuous forward run, PERIOD=2.
      seen_h.delete();
      pulse_start();
      while (rel < 650) cyc();
      check("fwd_len", 32'(seen_h.size()), 32'd6);
      for (int i = 0; i < 6 && i < seen_h.size(); i++)
         check("fwd_seq", 32'(seen_h[i]), 32'(H_TAB[((i + 1) % 6)*3 +: 3]));

      // STOP mid-step: hold, no DONE, no more steps.
      pulse_stop();
      repeat (300) cyc();
      check("stop_steps", 32'(seen_h.size()), 32'd6);
      check("stop_done", 32'(done_cnt), 32'd0);

      // Counted reverse move of 3 steps.
      seen_h.delete();
      bus.count = 8'd3; bus.dir = 1'b0;
      pulse_start();
      while (bus.busy && rel < 400) cyc();
      check("rev_busy", 32'(bus.busy), 32'd0);
      check("rev_len", 32'(seen_h.size()), 32'd3);
      for (int i = 0; i < 3 && i < seen_h.size(); i++)
         check("rev_seq", 32'(seen_h[i]), 32'(H_TAB[(5 - i)*3 +: 3]));
      check("rev_done", 32'(done_cnt), 32'd1);
      check("done_with_stb", 32'(done_wo_stb), 32'd0);
      repeat (20) cyc();

      // Reset in the middle of a counted move.
      done_cnt = 0; seen_h.delete();
      bus.count = 8'd5; bus.dir = 1'b1; bus.period = 16'd1;
      pulse_start();
      while (seen_h.size() < 2 && rel < 200) cyc();
      repeat (20) cyc();
      check("mid_steps", 32'(seen_h.size()), 32'd2);
      async_reset("rst_mid");
      repeat (400) cyc();
      check("rst_no_done", 32'(done_cnt), 32'd0);

      for (int run = 0; run < 16; run++) begin
         bus.period = 16'($urandom_range(1, 3));
         bus.count  = 8'($urandom_range(0, 4));
         bus.dir    = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 5)) cyc();
         pulse_start();
         lim = int'($urandom_range(150, 900));
         while (m_busy && rel < lim) begin
            if ($urandom_range(0, 63) == 0) bus.dir = ~bus.dir;
            if ($urandom_range(0, 99) == 0) bus.start = 1'b1;
            cyc();
            bus.start = 1'b0;
         end
         if (m_busy) pulse_stop();
         repeat (5) cyc();
      end

      // PERIOD=0 stalls, then PERIOD=1 steps every tick.
      seen_h.delete(); stb_rel.delete();
      bus.period = 16'd0; bus.count = 8'd0; bus.dir = 1'b1;
      pulse_start();
      while (rel < 10000) cyc();
      check("stall_busy", 32'(bus.busy), 32'd1);
      check("stall_steps", 32'(seen_h.size()), 32'd0);
      m_en = 1'b0;
      bus.period = 16'd1;
      while (stb_rel.size() < 3 && rel < 10300) cyc();
      check("p1_steps", 32'(stb_rel.size()), 32'd3);
      gap1 = (stb_rel.size() >= 2) ? stb_rel[1] - stb_rel[0] : -1;
      gap2 = (stb_rel.size() >= 3) ? stb_rel[2] - stb_rel[1] : -1;
      check("p1_gap1", 32'(gap1), 32'd50);
      check("p1_gap2", 32'(gap2), 32'd50);
      pulse_stop();
      check("p1_stop_busy", 32'(bus.busy), 32'd0);
      m_en = 1'b1;
      async_reset("rst_resync");

      // PERIOD cut from 100 to 3 while the timer sits at 50.
      seen_h.delete(); stb_rel.delete();
      bus.period = 16'd100;
      pulse_start();
      while (rel < 2510) cyc();
      m_en = 1'b0;
      bus.period = 16'd3;
      while (stb_rel.size() == 0 && rel < 5200) cyc();
      step_at = (stb_rel.size() > 0) ? stb_rel[0] : -1;
`ifdef HALL_PERIOD_LATCH_EN
      exp_at = 100 * TPS;
`else
      exp_at = 51 * TPS;
`endif
      check("period_change_step", 32'(step_at), 32'(exp_at));
      pulse_stop();
      check("final_busy", 32'(bus.busy), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
